// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 data mux onto a valid/ready port.
// Grants are burst-bounded to MAX_BURST beats with one idle bubble between grants.
module mux4_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       sel,
    output logic [3:0]       ack,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic [1:0] winner;
    logic [1:0] cand;
    logic       xfer;

    // Scan from farthest to nearest so the channel right after last_q wins.
    always_comb begin
        winner = last_q + 2'd1;
        cand   = last_q;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    assign sel       = sel_q;
    assign busy      = (state_q == GRANT);
    assign out_valid = busy & req[sel_q];
    assign xfer      = out_valid & out_ready;
    assign ack       = xfer ? (4'b0001 << sel_q) : 4'b0000;

    always_comb begin
        unique case (sel_q)
            2'd0:    out_data = in0;
            2'd1:    out_data = in1;
            2'd2:    out_data = in2;
            default: out_data = in3;
        endcase
    end

    // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_d    = GRANT;
                    sel_d      = winner;
                    last_d     = winner;
                    beat_cnt_d = 8'd0;
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q + 8'd1 == MAX_BURST_C) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= 2'd0;
            last_q     <= 2'd3;
            beat_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: one instance with MAX_BURST=4, one with MAX_BURST=1.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] in0, in1, in2, in3;
    logic       out_ready;

    logic       a_valid, b_valid;
    logic [7:0] a_data, b_data;
    logic [1:0] a_sel, b_sel;
    logic [3:0] a_ack, b_ack;
    logic       a_busy, b_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst(rst), .req(req),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out_ready(out_ready), .out_valid(a_valid), .out_data(a_data),
        .sel(a_sel), .ack(a_ack), .busy(a_busy)
    );

    mux4_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst), .req(req),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out_ready(out_ready), .out_valid(b_valid), .out_data(b_data),
        .sel(b_sel), .ack(b_ack), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic check_a_grant(input string tag, input logic [1:0] ch, input logic [3:0] ack_exp);
        #1;
        check({tag, "_busy"}, 32'(a_busy), 32'd1);
        check({tag, "_sel"}, 32'(a_sel), 32'(ch));
        check({tag, "_ack"}, 32'(a_ack), 32'(ack_exp));
    endtask

    initial begin
        in0 = 8'h11; in1 = 8'h22; in2 = 8'hA5; in3 = 8'h3C;
        rst = 1'b0; req = 4'b0000; out_ready = 1'b0;

        // Reset state
        do_reset();
        #1;
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_sel", 32'(a_sel), 32'd0);
        check("rst_ack", 32'(a_ack), 32'd0);
        check("rst_data", 32'(a_data), 32'h11);

        // 1: single request on ch2
        req = 4'b0100; out_ready = 1'b1;
        #1;
        check("t1_idle_busy", 32'(a_busy), 32'd0);
        step();
        #1;
        check("t1_sel", 32'(a_sel), 32'd2);
        check("t1_valid", 32'(a_valid), 32'd1);
        check("t1_data", 32'(a_data), 32'hA5);
        check("t1_ack", 32'(a_ack), 32'b0100);

        // 2: all request, rotation 0,1,2,3,0 with 4 beats and one bubble
        do_reset();
        req = 4'b1111; out_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            check($sformatf("t2_bubble%0d", g), 32'(a_busy), 32'd0);
            check($sformatf("t2_bubble_ack%0d", g), 32'(a_ack), 32'd0);
            step();
            for (int b = 0; b < 4; b++) begin
                check_a_grant($sformatf("t2_g%0d_b%0d", g, b), 2'(g % 4), 4'b0001 << (g % 4));
                step();
            end
        end

        // 3: ch1 stalled by out_ready=0, then a full 4-beat burst
        do_reset();
        req = 4'b0010; out_ready = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("t3_stall_sel%0d", c), 32'(a_sel), 32'd1);
            check($sformatf("t3_stall_valid%0d", c), 32'(a_valid), 32'd1);
            check($sformatf("t3_stall_ack%0d", c), 32'(a_ack), 32'd0);
            step();
        end
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            check_a_grant($sformatf("t3_beat%0d", b), 2'd1, 4'b0010);
            step();
        end
        #1;
        check("t3_release", 32'(a_busy), 32'd0);

        // 4: ch3 drops after 2 beats, ch0 pending -> wrap 3->0
        do_reset();
        req = 4'b1000; out_ready = 1'b1;
        step();
        check_a_grant("t4_b0", 2'd3, 4'b1000);
        step();
        check_a_grant("t4_b1", 2'd3, 4'b1000);
        step();
        req = 4'b0001;
        check_a_grant("t4_drop", 2'd3, 4'b0000);
        check("t4_drop_valid", 32'(a_valid), 32'd0);
        step();
        #1;
        check("t4_idle_busy", 32'(a_busy), 32'd0);
        check("t4_idle_valid", 32'(a_valid), 32'd0);
        check("t4_idle_data", 32'(a_data), 32'h3C);
        step();
        check_a_grant("t4_wrap", 2'd0, 4'b0001);

        // 5: reset during the 3rd beat of a ch2 burst
        do_reset();
        req = 4'b0100; out_ready = 1'b1;
        step();
        step();
        step();
        check_a_grant("t5_beat3", 2'd2, 4'b0100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0101;
        #1;
        check("t5_rst_valid", 32'(a_valid), 32'd0);
        check("t5_rst_sel", 32'(a_sel), 32'd0);
        check("t5_rst_busy", 32'(a_busy), 32'd0);
        step();
        for (int b = 0; b < 4; b++) begin
            check_a_grant($sformatf("t5_ch0_b%0d", b), 2'd0, 4'b0001);
            step();
        end
        #1;
        check("t5_bubble", 32'(a_busy), 32'd0);
        step();
        check_a_grant("t5_next_ch2", 2'd2, 4'b0100);

        // 6: MAX_BURST=1 instance alternates 0,3,0,3
        do_reset();
        req = 4'b1001; out_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            #1;
            check($sformatf("t6_bubble%0d", g), 32'(b_busy), 32'd0);
            step();
            #1;
            check($sformatf("t6_sel%0d", g), 32'(b_sel), (g % 2 == 0) ? 32'd0 : 32'd3);
            check($sformatf("t6_ack%0d", g), 32'(b_ack), (g % 2 == 0) ? 32'b0001 : 32'b1000);
            check($sformatf("t6_data%0d", g), 32'(b_data), (g % 2 == 0) ? 32'h11 : 32'h3C);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
